// File: rtl/median_window_gen.sv
// ============================================================================
// Module   : median_window_gen
// Brief    : Streaming 3x3 window generator feeding the 9-value sort/median.
//            Optional MEDIAN_WIN_ERR_EN adds the sticky err_sof output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module median_window_gen #(
    parameter int SIZE       = 8,
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [SIZE-1:0]   pix_data,
    input  logic              sof,
    output logic              win_valid,
    output logic [9*SIZE-1:0] win,
`ifdef MEDIAN_WIN_ERR_EN
    output logic              frame_done,
    output logic              err_sof
`else
    output logic              frame_done
`endif
);

    localparam int c_CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_WIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_HEIGHT - 1);
    localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
    localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);

    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;

    // r_lb0 holds line r-1, r_lb1 holds line r-2 at the current column
    logic [SIZE-1:0] r_lb0 [IMG_WIDTH];
    logic [SIZE-1:0] r_lb1 [IMG_WIDTH];

    // Shift array columns: index 0 oldest (c-2), index 2 newest (c)
    logic [SIZE-1:0] r_top [3];
    logic [SIZE-1:0] r_mid [3];
    logic [SIZE-1:0] r_bot [3];

    logic              r_win_valid;
    logic              r_frame_done;
    logic [9*SIZE-1:0] r_win;

    logic              w_start;
    logic [c_CW-1:0]   w_col;
    logic [c_RW-1:0]   w_row;
    logic              w_col_wrap;
    logic              w_row_wrap;
    logic              w_emit;
    logic              w_last;
    logic [SIZE-1:0]   w_top;
    logic [SIZE-1:0]   w_mid;
    logic [9*SIZE-1:0] w_win_next;

    // sof with a valid pixel forces position (0,0) for this very pixel
    assign w_start    = pix_valid & sof;
    assign w_col      = w_start ? '0 : r_col;
    assign w_row      = w_start ? '0 : r_row;
    assign w_col_wrap = (w_col == c_COL_LAST);
    assign w_row_wrap = (w_row == c_ROW_LAST);
    assign w_emit     = (w_row >= c_ROW_TWO) && (w_col >= c_COL_TWO);
    assign w_last     = w_row_wrap & w_col_wrap;

    assign w_top = r_lb1[w_col];
    assign w_mid = r_lb0[w_col];

    assign w_win_next = {r_top[1], r_top[2], w_top,
                         r_mid[1], r_mid[2], w_mid,
                         r_bot[1], r_bot[2], pix_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : w_row + c_RW'(1);
            end else begin
                r_col <= w_col + c_CW'(1);
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
        end else if (pix_valid) begin
            r_lb0[w_col] <= pix_data;
            r_lb1[w_col] <= w_mid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_top[i] <= '0;
                r_mid[i] <= '0;
                r_bot[i] <= '0;
            end
        end else if (pix_valid) begin
            r_top[0] <= r_top[1];
            r_top[1] <= r_top[2];
            r_top[2] <= w_top;
            r_mid[0] <= r_mid[1];
            r_mid[1] <= r_mid[2];
            r_mid[2] <= w_mid;
            r_bot[0] <= r_bot[1];
            r_bot[1] <= r_bot[2];
            r_bot[2] <= pix_data;
        end
    end

    // The output window only updates on emission so it holds across gaps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win        <= '0;
        end else begin
            r_win_valid  <= pix_valid & w_emit;
            r_frame_done <= pix_valid & w_emit & w_last;
            if (pix_valid && w_emit) begin
                r_win <= w_win_next;
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign win        = r_win;

`ifdef MEDIAN_WIN_ERR_EN
    logic r_err_sof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sof <= 1'b0;
        end else if (w_start && ((r_col != '0) || (r_row != '0))) begin
            r_err_sof <= 1'b1;
        end
    end

    assign err_sof = r_err_sof;
`endif

endmodule

`default_nettype wire

// File: tb/tb_median_window_gen.sv
// ============================================================================
// Module   : tb_median_window_gen
// Brief    : Directed self-checking bench for median_window_gen (4x4, 8-bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_median_window_gen;

    localparam int c_W  = 4;
    localparam int c_H  = 4;
    localparam int c_SZ = 8;

    logic                clk;
    logic                rst_n;
    logic                pix_valid;
    logic [c_SZ-1:0]     pix_data;
    logic                sof;
    logic                win_valid;
    logic [9*c_SZ-1:0]   win;
    logic                frame_done;
`ifdef MEDIAN_WIN_ERR_EN
    logic                err_sof;
`endif

    int                  n_cmp;
    int                  n_fail;
    int                  n_win;
    logic [9*c_SZ-1:0]   last_exp;
    logic [9*c_SZ-1:0]   cap [4];

    median_window_gen #(
        .SIZE       (c_SZ),
        .IMG_WIDTH  (c_W),
        .IMG_HEIGHT (c_H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .sof        (sof),
        .win_valid  (win_valid),
        .win        (win),
`ifdef MEDIAN_WIN_ERR_EN
        .frame_done (frame_done),
        .err_sof    (err_sof)
`else
        .frame_done (frame_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Neighbourhood of centre (r-1,c-1) when pixel value = base + raster index
    function automatic logic [71:0] mk(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dr = -2; dr <= 0; dr++) begin
            for (int dc = -2; dc <= 0; dc++) begin
                w = {w[63:0], 8'(base + (r + dr) * c_W + (c + dc))};
            end
        end
        return w;
    endfunction

    task automatic send(input string tag, input logic [7:0] d, input bit s,
                        input bit exp_v, input logic [71:0] exp_w, input bit exp_fd);
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        sof       = s;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 72'(win_valid), 72'(exp_v));
        chk({tag, "_fdone"}, 72'(frame_done), 72'(exp_fd));
        if (exp_v) begin
            chk({tag, "_win"}, win, exp_w);
            last_exp = exp_w;
        end
        if (win_valid === 1'b1) begin
            if (n_win < 4) cap[n_win] = win;
            n_win++;
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'b0;
            pix_data  = 8'hEE;
            @(posedge clk);
            #1;
            chk({tag, "_gap_valid"}, 72'(win_valid), 72'd0);
            chk({tag, "_gap_fdone"}, 72'(frame_done), 72'd0);
            chk({tag, "_gap_hold"}, win, last_exp);
        end
    endtask

    task automatic send_frame(input string tag, input int base, input bit use_sof, input bit gaps);
        int r;
        int c;
        n_win = 0;
        for (int i = 0; i < c_W * c_H; i++) begin
            r = i / c_W;
            c = i % c_W;
            send($sformatf("%s_p%0d", tag, i), 8'(base + i), use_sof && (i == 0),
                 (r >= 2) && (c >= 2), mk(base, r, c), i == c_W * c_H - 1);
            if (gaps && i < c_W * c_H - 1 && $urandom_range(0, 1) == 1)
                idle($sformatf("%s_p%0d", tag, i), $urandom_range(1, 3));
        end
        chk({tag, "_nwin"}, 72'(n_win), 72'd4);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        n_win     = 0;
        last_exp  = '0;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        sof       = 1'b0;

        // 1: reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 72'(win_valid), 72'd0);
        chk("rst_fdone", 72'(frame_done), 72'd0);
        chk("rst_win", win, 72'd0);
`ifdef MEDIAN_WIN_ERR_EN
        chk("rst_err", 72'(err_sof), 72'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 2: continuous frame
        send_frame("t2", 0, 1'b1, 1'b0);
        chk("t2_first", cap[0], 72'h00_01_02_04_05_06_08_09_0A);
        chk("t2_last",  cap[3], 72'h05_06_07_09_0A_0B_0D_0E_0F);
        idle("t2", 2);

        // 3: same frame with random gaps
        send_frame("t3", 0, 1'b1, 1'b1);
        chk("t3_first", cap[0], 72'h00_01_02_04_05_06_08_09_0A);
        chk("t3_last",  cap[3], 72'h05_06_07_09_0A_0B_0D_0E_0F);

        // 4: back-to-back frames
        send_frame("t4a", 0, 1'b1, 1'b0);
        send_frame("t4b", 100, 1'b1, 1'b0);
        chk("t4b_first", cap[0], 72'h64_65_66_68_69_6A_6C_6D_6E);
`ifdef MEDIAN_WIN_ERR_EN
        chk("t4_err", 72'(err_sof), 72'd0);
`endif

        // 5: frame A aborted by sof at index 6, then full frame B
        for (int i = 0; i < 6; i++)
            send($sformatf("t5a_p%0d", i), 8'(i), i == 0, 1'b0, 72'd0, 1'b0);
        send_frame("t5b", 200, 1'b1, 1'b0);
        chk("t5b_first", cap[0], 72'hC8_C9_CA_CC_CD_CE_D0_D1_D2);
`ifdef MEDIAN_WIN_ERR_EN
        chk("t5_err", 72'(err_sof), 72'd1);
`endif

        // 6: reset mid-frame after index 9, then fresh frame without sof
        for (int i = 0; i < 10; i++)
            send($sformatf("t6a_p%0d", i), 8'(50 + i), i == 0, 1'b0, 72'd0, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("t6_rst_valid", 72'(win_valid), 72'd0);
        chk("t6_rst_win", win, 72'd0);
        chk("t6_rst_fdone", 72'(frame_done), 72'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("t6_rst_hold_valid", 72'(win_valid), 72'd0);
        end
`ifdef MEDIAN_WIN_ERR_EN
        chk("t6_rst_err", 72'(err_sof), 72'd0);
`endif
        @(negedge clk);
        rst_n    = 1'b1;
        last_exp = '0;
        send_frame("t6b", 150, 1'b0, 1'b0);
        chk("t6b_first", cap[0], 72'h96_97_98_9A_9B_9C_9E_9F_A0);
        idle("t6b", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
